pll_supervisor: RTL and testbench

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

---
 rtl/pll_supervisor.sv | 142 ++++++++++++++
 tb/tb_pll_supervisor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_supervisor.sv
// PLL supervisor: pulses the PLL reset, waits for a filtered lock, holds the
// downstream reset for a few cycles and then reports ready. Any loss of lock
// after the filter stage restarts the sequence and is counted in fail_count.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// PLLRST    | pll_rst asserted for RST_PULSE cycles
// WAIT_LOCK | waiting for synchronized lock, retry after LOCK_TIMEOUT cycles
// FILTER    | lock must stay high LOCK_FILTER consecutive cycles
// HOLD      | lock stable, sys_reset held RST_HOLD more cycles
// RUN       | sys_reset released, ready high until lock drops
module pll_supervisor #(
   parameter int RST_PULSE    = 25,
   parameter int LOCK_TIMEOUT = 250000,
   parameter int LOCK_FILTER  = 2500,
   parameter int RST_HOLD     = 16
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       locked,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic [7:0] fail_count,
   output logic [2:0] state
);

   // Zero or negative parameters would make a state last no time at all;
   // clamping to 1 keeps every state at least one cycle long.
   localparam int RP_C = (RST_PULSE    < 1) ? 1 : RST_PULSE;
   localparam int LT_C = (LOCK_TIMEOUT < 1) ? 1 : LOCK_TIMEOUT;
   localparam int LF_C = (LOCK_FILTER  < 1) ? 1 : LOCK_FILTER;
   localparam int RH_C = (RST_HOLD     < 1) ? 1 : RST_HOLD;

   localparam int MAX_AB = (RP_C > LT_C) ? RP_C : LT_C;
   localparam int MAX_CD = (LF_C > RH_C) ? LF_C : RH_C;
   localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = ($clog2(MAX_P + 1) > 24) ? $clog2(MAX_P + 1) : 24;

   localparam logic [CW-1:0] RP_TC = CW'(RP_C - 1);
   localparam logic [CW-1:0] LT_TC = CW'(LT_C - 1);
   localparam logic [CW-1:0] LF_TC = CW'(LF_C - 1);
   localparam logic [CW-1:0] RH_TC = CW'(RH_C - 1);

   typedef enum logic [2:0] {
      PLLRST    = 3'd0,
      WAIT_LOCK = 3'd1,
      FILTER    = 3'd2,
      HOLD      = 3'd3,
      RUN       = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    fail_q, fail_d;
   logic          sync1_q, locked_s_q;
   logic          pll_rst_q, sys_reset_q, ready_q;
   logic          bump;

   // Two-flop synchronizer for the asynchronous PLL lock pin.
   always_ff @(posedge clkin) begin
      if (reset) begin
         sync1_q    <= 1'b0;
         locked_s_q <= 1'b0;
      end else begin
         sync1_q    <= locked;
         locked_s_q <= sync1_q;
      end
   end

   // Next-state, shared counter and failure-count logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      fail_d  = fail_q;
      bump    = 1'b0;
      unique case (state_q)
         PLLRST: begin
            if (cnt_q == RP_TC) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s_q) begin
               state_d = FILTER;
            end else if (cnt_q == LT_TC) begin
               state_d = PLLRST;
               bump    = 1'b1;
            end
         end
         FILTER: begin
            // A glitch here is not a failure, just a restart of the wait.
            if (!locked_s_q)          state_d = WAIT_LOCK;
            else if (cnt_q == LF_TC)  state_d = HOLD;
         end
         HOLD: begin
            if (!locked_s_q) begin
               state_d = PLLRST;
               bump    = 1'b1;
            end else if (cnt_q == RH_TC) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Counter is frozen so it never wraps during long lock periods.
            cnt_d = cnt_q;
            if (!locked_s_q) begin
               state_d = PLLRST;
               bump    = 1'b1;
            end
         end
         default: state_d = PLLRST;
      endcase
      if (bump && (fail_q != 8'hFF)) fail_d = fail_q + 8'd1;
      if (state_d != state_q)        cnt_d  = '0;
   end

   // State, counter and outputs; outputs are registered from the next state
   // so they change on the same edge as the state register.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q     <= PLLRST;
         cnt_q       <= '0;
         fail_q      <= 8'd0;
         pll_rst_q   <= 1'b1;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fail_q      <= fail_d;
         pll_rst_q   <= (state_d == PLLRST);
         sys_reset_q <= (state_d != RUN);
         ready_q     <= (state_d == RUN);
      end
   end

   assign pll_rst    = pll_rst_q;
   assign sys_reset  = sys_reset_q;
   assign ready      = ready_q;
   assign fail_count = fail_q;
   assign state      = state_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: directed sequences plus randomized lock behaviour.
// Stimulus pushes predicted outputs into a queue; a monitor pops and compares.
module tb_pll_supervisor;

   localparam int RP = 4;
   localparam int LT = 20;
   localparam int LF = 8;
   localparam int RH = 3;

   logic       clkin = 1'b0;
   logic       reset = 1'b1;
   logic       locked = 1'b0;
   logic       pll_rst, sys_reset, ready;
   logic [7:0] fail_count;
   logic [2:0] state;

   pll_supervisor #(
      .RST_PULSE   (RP),
      .LOCK_TIMEOUT(LT),
      .LOCK_FILTER (LF),
      .RST_HOLD    (RH)
   ) dut (
      .clkin     (clkin),
      .reset     (reset),
      .locked    (locked),
      .pll_rst   (pll_rst),
      .sys_reset (sys_reset),
      .ready     (ready),
      .fail_count(fail_count),
      .state     (state)
   );

   always #5 clkin = ~clkin;

   typedef struct packed {
      logic [2:0] st;
      logic       pr;
      logic       sr;
      logic       rd;
      logic [7:0] fc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference: phase number, cycles spent in it, failure tally, and the
   // last two lock samples (the synchronizer delay).
   int m_phase = 0;
   int m_cnt   = 0;
   int m_fail  = 0;
   bit m_s1    = 0;
   bit m_s2    = 0;

   function automatic void model_edge(input bit rst, input bit lk);
      int nxt;
      bit ls;
      bit bump;
      if (rst) begin
         m_phase = 0; m_cnt = 0; m_fail = 0; m_s1 = 0; m_s2 = 0;
         return;
      end
      ls   = m_s2;
      nxt  = m_phase;
      bump = 0;
      case (m_phase)
         0: if (m_cnt + 1 >= RP) nxt = 1;
         1: if (ls) nxt = 2;
            else if (m_cnt + 1 >= LT) begin nxt = 0; bump = 1; end
         2: if (!ls) nxt = 1;
            else if (m_cnt + 1 >= LF) nxt = 3;
         3: if (!ls) begin nxt = 0; bump = 1; end
            else if (m_cnt + 1 >= RH) nxt = 4;
         default: if (!ls) begin nxt = 0; bump = 1; end
      endcase
      if (bump && m_fail < 255) m_fail++;
      m_cnt   = (nxt == m_phase) ? m_cnt + 1 : 0;
      m_phase = nxt;
      m_s2    = m_s1;
      m_s1    = lk;
   endfunction

   task automatic step(input bit rst, input bit lk);
      exp_t e;
      reset  = rst;
      locked = lk;
      model_edge(rst, lk);
      e.st = m_phase[2:0];
      e.pr = (m_phase == 0);
      e.sr = (m_phase != 4);
      e.rd = (m_phase == 4);
      e.fc = m_fail[7:0];
      q.push_back(e);
      @(posedge clkin);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every cycle the DUT presents outputs; compare against queue.
   initial begin : monitor
      exp_t e;
      exp_t a;
      forever begin
         @(negedge clkin);
         if (q.size() > 0) begin
            e = q.pop_front();
            a = {state, pll_rst, sys_reset, ready, fail_count};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs @%0t: got st=%0d pr=%b sr=%b rd=%b fc=%0d expected st=%0d pr=%b sr=%b rd=%b fc=%0d",
                        $time, a.st, a.pr, a.sr, a.rd, a.fc, e.st, e.pr, e.sr, e.rd, e.fc);
            end
         end
      end
   end

   initial begin : stim
      int len;
      bit lk;
      // Lock tied high: ready exactly 16 cycles after reset release.
      repeat (3) step(1, 1);
      chk("reset_state", state, 0);
      chk("reset_pll_rst", pll_rst, 1);
      chk("reset_sys_reset", sys_reset, 1);
      chk("reset_ready", ready, 0);
      for (int k = 1; k <= 20; k++) begin
         step(0, 1);
         if (k == 3)  chk("pll_rst_pulse_end", pll_rst, 1);
         if (k == 4)  chk("pll_rst_released", pll_rst, 0);
         if (k == 15) chk("ready_before_16", ready, 0);
         if (k == 16) chk("ready_at_16", ready, 1);
         if (k == 16) chk("sys_reset_at_16", sys_reset, 0);
      end
      chk("clean_lock_fail", fail_count, 0);

      // Lock loss in RUN, then relock.
      repeat (3) step(0, 0);
      chk("runloss_state", state, 0);
      chk("runloss_sys_reset", sys_reset, 1);
      repeat (7) step(0, 0);
      repeat (30) step(0, 1);
      chk("relock_ready", ready, 1);
      chk("relock_fail", fail_count, 1);

      // Lock never arrives: periodic retries, count saturates at 255.
      step(1, 0);
      for (int k = 1; k <= 300 * (RP + LT); k++) begin
         step(0, 0);
         if (k == RP + LT)     chk("first_timeout_fail", fail_count, 1);
         if (k == 2 * (RP + LT)) chk("second_timeout_fail", fail_count, 2);
      end
      chk("saturated_fail", fail_count, 255);
      chk("saturated_sys_reset", sys_reset, 1);
      chk("saturated_ready", ready, 0);

      // One-cycle lock glitch during FILTER delays ready to cycle 23.
      repeat (2) step(1, 1);
      for (int k = 1; k <= 30; k++) begin
         step(0, (k == 9) ? 1'b0 : 1'b1);
         if (k == 11) chk("glitch_back_to_wait", state, 1);
         if (k == 22) chk("glitch_ready_22", ready, 0);
         if (k == 23) chk("glitch_ready_23", ready, 1);
      end
      chk("glitch_fail", fail_count, 0);

      // Reset during HOLD after one timeout.
      step(1, 0);
      repeat (RP + LT + 1) step(0, 0);
      for (int i = 0; i < 100 && m_phase != 3; i++) step(0, 1);
      chk("reached_hold", state, 3);
      chk("pre_reset_fail_hold", fail_count, 1);
      step(1, 1);
      chk("rst_hold_state", state, 0);
      chk("rst_hold_pll_rst", pll_rst, 1);
      chk("rst_hold_sys_reset", sys_reset, 1);
      chk("rst_hold_ready", ready, 0);
      chk("rst_hold_fail", fail_count, 0);

      // Reset during RUN after one timeout.
      repeat (RP + LT + 1) step(0, 0);
      for (int i = 0; i < 100 && m_phase != 4; i++) step(0, 1);
      repeat (3) step(0, 1);
      chk("reached_run", state, 4);
      step(1, 1);
      chk("rst_run_state", state, 0);
      chk("rst_run_ready", ready, 0);
      chk("rst_run_fail", fail_count, 0);

      // Randomized lock behaviour with occasional resets.
      step(1, 1);
      for (int n = 0; n < 2500; ) begin
         lk  = ($urandom_range(0, 3) != 0);
         len = lk ? $urandom_range(1, 40) : $urandom_range(1, 30);
         for (int j = 0; j < len; j++) begin
            step(($urandom_range(0, 299) == 0), lk);
            n++;
         end
      end

      repeat (2) @(negedge clkin);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
